// File: rtl/hazard_stall_ctrl_if.sv
// Control bundle between the hazard/stall controller and the pipeline datapath.
// master = datapath side (drives decode info), slave = controller side.
interface hazard_stall_ctrl_if #(
  parameter int register_addr = 5,
  parameter int CNT_WIDTH     = 16
);
  logic                     mem_r_pip;
  logic [register_addr-1:0] wb_addr_pip;
  logic [register_addr-1:0] rs_id;
  logic [register_addr-1:0] rt_id;
  logic                     rt_used_id;
  logic                     mdu_start_id;
  logic                     branch_taken_ex;
  logic                     pc_en;
  logic                     if_id_en;
  logic                     id_ex_en;
  logic                     if_id_flush;
  logic                     id_ex_flush;
  logic                     ex_mem_flush;
  logic                     mdu_busy;
  logic [CNT_WIDTH-1:0]     stall_cnt;
  logic [CNT_WIDTH-1:0]     flush_cnt;

  modport master (
    output mem_r_pip, wb_addr_pip, rs_id, rt_id, rt_used_id, mdu_start_id, branch_taken_ex,
    input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, mdu_busy,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  mem_r_pip, wb_addr_pip, rs_id, rt_id, rt_used_id, mdu_start_id, branch_taken_ex,
    output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, mdu_busy,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, taken-branch flush and MDU freeze control for the 5-stage pipeline.
// Optional perf counters (stall_cnt/flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int register_addr = 5,
  parameter int MDU_LATENCY   = 4,
  parameter int CNT_WIDTH     = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int CW = $clog2(MDU_LATENCY) + 1;
  localparam logic [CW-1:0]            CNT_LOAD = (MDU_LATENCY > 1) ? CW'(MDU_LATENCY - 2) : '0;
  localparam logic [register_addr-1:0] ZERO_REG = '0;

  typedef enum logic {RUN, MDU_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_use;
  logic          pc_en, if_id_en, id_ex_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mdu_busy;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = bus.mem_r_pip && (bus.wb_addr_pip != ZERO_REG) &&
                    ((bus.wb_addr_pip == bus.rs_id) ||
                     (bus.rt_used_id && (bus.wb_addr_pip == bus.rt_id)));

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first; a missed branch would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mdu_busy     = 1'b0;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.branch_taken_ex) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed; PC loads the target.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (bus.mdu_start_id && (MDU_LATENCY > 1)) begin
            // The MDU op enters EX this cycle; the busy phase covers its remaining cycles.
            state_d = MDU_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        MDU_BUSY: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          mdu_busy     = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mdu_busy     = mdu_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if ((state_q == RUN) && bus.branch_taken_ex && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = {CNT_WIDTH{1'b0}};
  assign bus.flush_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected control vectors are queued as stimulus is
// driven and compared at the following falling edge. Counter checks follow HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;
  localparam int RA  = 5;
  localparam int CNW = 2;

  // Control vector: {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, mdu_busy}
  localparam logic [6:0] V_RUN = 7'b111_000_0;
  localparam logic [6:0] V_RST = 7'b000_111_0;
  localparam logic [6:0] V_HAZ = 7'b001_010_0;
  localparam logic [6:0] V_BR  = 7'b111_110_0;
  localparam logic [6:0] V_MDU = 7'b000_001_1;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNW-1:0] STALL_SAT = 2'd3;
  localparam logic [CNW-1:0] FLUSH_ONE = 2'd1;
`else
  localparam logic [CNW-1:0] STALL_SAT = 2'd0;
  localparam logic [CNW-1:0] FLUSH_ONE = 2'd0;
`endif

  typedef struct packed {
    logic          mem_r;
    logic [RA-1:0] wb;
    logic [RA-1:0] rs;
    logic [RA-1:0] rt;
    logic          rt_used;
    logic          mdu;
    logic          br;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  logic [6:0]     sb[$];
  logic [6:0]     exp_v;
  logic [6:0]     obs;
  logic [CNW-1:0] cnt_exp;

  hazard_stall_ctrl_if #(.register_addr(RA), .CNT_WIDTH(CNW)) bus ();

  hazard_stall_ctrl #(.register_addr(RA), .MDU_LATENCY(4), .CNT_WIDTH(CNW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.if_id_flush,
                bus.id_ex_flush, bus.ex_mem_flush, bus.mdu_busy};

  function automatic stim_t mk(bit mem_r, int wb, int rs, int rt, bit rt_used, bit mdu, bit br);
    stim_t s;
    s.mem_r   = mem_r;
    s.wb      = RA'(wb);
    s.rs      = RA'(rs);
    s.rt      = RA'(rt);
    s.rt_used = rt_used;
    s.mdu     = mdu;
    s.br      = br;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.mem_r_pip       = s.mem_r;
    bus.wb_addr_pip     = s.wb;
    bus.rs_id           = s.rs;
    bus.rt_id           = s.rt;
    bus.rt_used_id      = s.rt_used;
    bus.mdu_start_id    = s.mdu;
    bus.branch_taken_ex = s.br;
  endtask

  // One cycle of stimulus: drive just after the rising edge, queue the expectation,
  // return at the falling edge where the caller pops and compares.
  task automatic apply(input stim_t s, input logic [6:0] e);
    @(posedge clk);
    #1;
    drive(s);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    sb.push_back(V_RST);
    @(negedge clk);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL reset_outputs: got %b expected %b", obs, exp_v);
    else passes++;
    checks++;
    if (bus.stall_cnt !== 2'd0 || bus.flush_cnt !== 2'd0)
      $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", bus.stall_cnt, bus.flush_cnt);
    else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back(V_RUN);
    @(negedge clk);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL reset_release: got %b expected %b", obs, exp_v);
    else passes++;
  endtask

  task automatic test_load_use();
    stim_t      st[$];
    logic [6:0] ex[$];
    st.push_back(mk(1, 5, 5, 0, 0, 0, 0)); ex.push_back(V_HAZ);  // rs match
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0)); ex.push_back(V_RUN);  // cleared next cycle
    st.push_back(mk(1, 5, 3, 5, 1, 0, 0)); ex.push_back(V_HAZ);  // rt match, rt used
    st.push_back(mk(1, 0, 0, 0, 1, 0, 0)); ex.push_back(V_RUN);  // r0 never stalls
    st.push_back(mk(1, 5, 3, 5, 0, 0, 0)); ex.push_back(V_RUN);  // rt match, rt unused
    st.push_back(mk(0, 5, 5, 5, 1, 0, 0)); ex.push_back(V_RUN);  // not a load
    st.push_back(mk(1, 31, 31, 0, 0, 0, 0)); ex.push_back(V_HAZ); // top register
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i], ex[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL load_use[%0d]: got %b expected %b", i, obs, exp_v);
      else passes++;
    end
  endtask

  task automatic test_branch_priority();
    stim_t      st[$];
    logic [6:0] ex[$];
    do_reset();
    st.push_back(mk(1, 5, 5, 0, 0, 0, 1)); ex.push_back(V_BR);   // branch beats load-use
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0)); ex.push_back(V_RUN);
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i], ex[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL branch_hazard[%0d]: got %b expected %b", i, obs, exp_v);
      else passes++;
    end
    checks++;
    if (bus.flush_cnt !== FLUSH_ONE)
      $display("FAIL flush_cnt: got %0d expected %0d", bus.flush_cnt, FLUSH_ONE);
    else passes++;
    checks++;
    if (bus.stall_cnt !== 2'd0)
      $display("FAIL stall_cnt_after_branch: got %0d expected 0", bus.stall_cnt);
    else passes++;
    st.delete();
    ex.delete();
    st.push_back(mk(0, 0, 0, 0, 0, 1, 1)); ex.push_back(V_BR);   // branch beats MDU entry
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0)); ex.push_back(V_RUN);  // so no busy phase
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i], ex[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL branch_mdu[%0d]: got %b expected %b", i, obs, exp_v);
      else passes++;
    end
  endtask

  task automatic test_mdu();
    stim_t      st[$];
    logic [6:0] ex[$];
    st.push_back(mk(0, 0, 0, 0, 0, 1, 0)); ex.push_back(V_RUN);
    for (int k = 0; k < 3; k++) begin
      st.push_back(mk(1, 5, 5, 0, 0, 0, 1)); ex.push_back(V_MDU);  // branch/hazard ignored
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0)); ex.push_back(V_RUN);
    st.push_back(mk(1, 7, 7, 0, 0, 1, 0)); ex.push_back(V_HAZ);    // stall wins over entry
    st.push_back(mk(0, 0, 0, 0, 0, 1, 0)); ex.push_back(V_RUN);    // entry re-evaluated
    for (int k = 0; k < 3; k++) begin
      st.push_back(mk(0, 0, 0, 0, 0, 0, 0)); ex.push_back(V_MDU);
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0)); ex.push_back(V_RUN);
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i], ex[i]);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL mdu_seq[%0d]: got %b expected %b", i, obs, exp_v);
      else passes++;
    end
  endtask

  task automatic test_mdu_reset();
    apply(mk(0, 0, 0, 0, 0, 1, 0), V_RUN);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL mdu_rst_entry: got %b expected %b", obs, exp_v);
    else passes++;
    apply(mk(0, 0, 0, 0, 0, 0, 0), V_MDU);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL mdu_rst_busy1: got %b expected %b", obs, exp_v);
    else passes++;
    @(posedge clk);
    #1;
    sb.push_back(V_MDU);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL mdu_rst_busy2: got %b expected %b", obs, exp_v);
    else passes++;
    #1;
    rst = 1'b1;
    sb.push_back(V_RST);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL mdu_rst_async: got %b expected %b", obs, exp_v);
    else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back(V_RUN);
    @(negedge clk);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL mdu_rst_release: got %b expected %b", obs, exp_v);
    else passes++;
    apply(mk(0, 0, 0, 0, 0, 0, 0), V_RUN);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL mdu_rst_stays_run: got %b expected %b", obs, exp_v);
    else passes++;
  endtask

  task automatic test_perf_cnt();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(mk(1, 9, 9, 0, 0, 0, 0), V_HAZ);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL perf_stall[%0d]: got %b expected %b", i, obs, exp_v);
      else passes++;
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0), V_RUN);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v) $display("FAIL perf_idle: got %b expected %b", obs, exp_v);
    else passes++;
    cnt_exp = STALL_SAT;
    checks++;
    if (bus.stall_cnt !== cnt_exp)
      $display("FAIL stall_cnt_sat: got %0d expected %0d", bus.stall_cnt, cnt_exp);
    else passes++;
    checks++;
    if (bus.flush_cnt !== 2'd0)
      $display("FAIL flush_cnt_idle: got %0d expected 0", bus.flush_cnt);
    else passes++;
  endtask

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mdu();
    test_mdu_reset();
    test_perf_cnt();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage CPU, sitting beside the forwarding logic.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Flushes wrong-path instructions on a taken branch resolved in EX.
- Freezes the front end while a multi-cycle multiply/divide unit (MDU) occupies EX.
- Drives the PC enable and the pipeline-register enable/flush controls.

Parameters:
register_addr, 5, register address width
MDU_LATENCY, 4, total cycles an MDU instruction occupies EX (>=1)
CNT_WIDTH, 16, width of the performance counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
mem_r_pip  input  1  instruction in EX is a load
wb_addr_pip  input  register_addr  destination register of the EX instruction
rs_id  input  register_addr  rs of the ID instruction
rt_id  input  register_addr  rt of the ID instruction
rt_used_id  input  1  ID instruction reads rt
mdu_start_id  input  1  ID instruction is a multiply/divide
branch_taken_ex  input  1  branch in EX resolved taken
pc_en  output  1  PC load enable
if_id_en  output  1  IF/ID register enable
id_ex_en  output  1  ID/EX register enable
if_id_flush  output  1  clear IF/ID to NOP
id_ex_flush  output  1  clear ID/EX to NOP
ex_mem_flush  output  1  clear EX/MEM to NOP
mdu_busy  output  1  high while in state MDU_BUSY
stall_cnt  output  CNT_WIDTH  stall cycles counted (optional feature)
flush_cnt  output  CNT_WIDTH  branch flushes counted (optional feature)

Behaviour:
- States: RUN and MDU_BUSY. Down-counter `cnt` has width clog2(MDU_LATENCY)+1.
- Enables and flushes are combinational from state and inputs. State, `cnt` and the perf counters are registered.
- While rst is high:
  - state=RUN, cnt=0, counters=0.
  - pc_en, if_id_en and id_ex_en are 0.
  - All flush outputs are 1; mdu_busy is 0.
- Defaults in RUN: pc_en, if_id_en and id_ex_en are 1; all flushes are 0.
- Load-use hazard (RUN) = mem_r_pip && wb_addr_pip!=0 && (wb_addr_pip==rs_id || (rt_used_id && wb_addr_pip==rt_id)).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle.
  - The hazard self-clears next cycle because the load has moved to MEM.
- Taken branch (RUN, branch_taken_ex=1):
  - if_id_flush=1, id_ex_flush=1, pc_en=1 (PC takes the target).
  - Has priority over the load-use hazard, whose stall is suppressed.
  - Has priority over mdu_start_id; no MDU entry occurs.
- MDU entry (RUN, mdu_start_id=1, no hazard, no branch, MDU_LATENCY>1):
  - The instruction advances into EX normally this cycle.
  - Next state=MDU_BUSY, cnt=MDU_LATENCY-2.
- MDU_BUSY:
  - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1; mdu_busy=1.
  - branch_taken_ex and the hazard inputs are ignored.
  - When cnt==0, next state=RUN; otherwise cnt decrements.
  - Net effect: MDU_LATENCY-1 frozen cycles, and the MDU instruction occupies EX for MDU_LATENCY cycles.
- MDU_LATENCY=1: never enters MDU_BUSY; mdu_start_id has no effect.
- A load-use hazard and mdu_start_id together: the stall wins, and MDU entry is re-evaluated next cycle.
- rst asserted mid-MDU_BUSY: immediate return to RUN, cnt=0.
- Perf counters saturate at all-ones and never wrap.
  - stall_cnt increments on every cycle with pc_en=0 while not in reset.
  - flush_cnt increments on each RUN cycle with branch_taken_ex=1.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cnt and flush_cnt registers exist and behave as above.
- Undefined: no counter flops; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- Reset release, all inputs 0 -> pc_en=1, if_id_en=1, id_ex_en=1, all flushes 0, mdu_busy=0.
- mem_r_pip=1, wb_addr_pip=5, rs_id=5 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only.
  - Same stimulus with wb_addr_pip=0 -> no stall.
  - rt_id=5 with rt_used_id=0 -> no stall.
- Load-use hazard and branch_taken_ex=1 in the same cycle -> pc_en=1, if_id_flush=1, id_ex_flush=1; flush_cnt increments by 1.
- MDU_LATENCY=4, mdu_start_id pulse in RUN -> mdu_busy=1 and ex_mem_flush=1 for exactly 3 cycles starting next cycle, then RUN; branch_taken_ex=1 during those cycles is ignored.
- rst asserted in the second MDU_BUSY cycle -> outputs take reset values asynchronously; after release, state=RUN and pc_en=1.
- With HAZARD_PERF_CNT_EN and CNT_WIDTH=2, hold a continuous stall condition for 5 cycles -> stall_cnt saturates at 3. Without the macro -> stall_cnt=0.
